// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and counter width for the stream multiplexer
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int CW = 16;
endpackage

// File: rtl/mux_nx1_stream_if.sv
// mux_nx1_stream_if: N producer streams in, one registered stream out, plus mode/select and beat count
interface mux_nx1_stream_if import mux_pkg::*; #(parameter int N = 4, parameter int W = 8);
  localparam int SW = $clog2(N);
  logic mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [SW-1:0] out_chan;
  logic [CW-1:0] beat_count;
  modport slave (
    input mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan, beat_count
  );
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input in_ready, out_data, out_valid, out_chan, beat_count
  );
endinterface

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// rr_arbiter: picks the first requester after ptr, wrapping at N-1
module rr_arbiter #(parameter int N = 4, localparam int SW = $clog2(N)) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);
  always_comb begin
    int k;
    k = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // scan farthest offset first so the nearest requester after ptr wins
    for (int i = N; i >= 1; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        gnt = N'(1) << k;
        idx = SW'(k);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: registered N:1 stream mux with fixed or round-robin selection and saturating beat count
module mux_nx1_stream import mux_pkg::*; #(parameter int N = 4, parameter int W = 8) (
  input logic clk,
  input logic reset_n,
  mux_nx1_stream_if.slave s
);
  localparam int SW = $clog2(N);
  logic [SW-1:0] ptr_q, ptr_d, chan_q, chan_d, c, rr_idx;
  logic [W-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic [N-1:0] rr_gnt, ready;
  logic rr_any, has_c, load_en, xfer;
  rr_arbiter #(.N(N)) u_arb (
    .req(s.in_valid),
    .ptr(ptr_q),
    .gnt(rr_gnt),
    .idx(rr_idx),
    .any(rr_any)
  );
  always_comb begin
    load_en = !valid_q | s.out_ready;
    c = (s.mode == MODE_RR) ? rr_idx : s.sel;
    has_c = (s.mode == MODE_RR) ? rr_any : (int'(s.sel) < N);
    // ready stays low while reset is held, even though the output looks empty
    ready = (reset_n && has_c && load_en) ? N'(1) << c : '0;
    xfer = |(ready & s.in_valid);
    data_d = xfer ? s.in_data[int'(c)*W +: W] : data_q;
    chan_d = xfer ? c : chan_q;
    valid_d = xfer | (valid_q & !s.out_ready);
    cnt_d = (xfer && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    ptr_d = (xfer && s.mode == MODE_RR) ? c : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= SW'(N - 1);
      chan_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      chan_q <= chan_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
    end
  end
  assign s.in_ready = ready;
  assign s.out_data = data_q;
  assign s.out_valid = valid_q;
  assign s.out_chan = chan_q;
  assign s.beat_count = cnt_q;
endmodule
